// File: rtl/ttt_pkg.sv
// Shared op codes, stage/state encodings and op classification for the
// ttt instruction scheduler.
package ttt_pkg;

  localparam logic [3:0] OP_NOP     = 4'b0000;
  localparam logic [3:0] OP_INPUT   = 4'b0001;
  localparam logic [3:0] OP_ADVANCE = 4'b0010;
  localparam logic [3:0] OP_DUR     = 4'b1001;
  localparam logic [3:0] OP_GTH     = 4'b1010;
  localparam logic [3:0] OP_BTH     = 4'b1011;
  localparam logic [3:0] OP_GW      = 4'b1100;
  localparam logic [3:0] OP_BW      = 4'b1101;
  localparam logic [3:0] OP_INDPTR  = 4'b1110;
  localparam logic [3:0] OP_IDX     = 4'b1111;

  typedef enum logic [1:0] {
    STAGE_WAIT   = 2'b00,
    STAGE_UPDATE = 2'b01,
    STAGE_CHECK  = 2'b10,
    STAGE_XMIT   = 2'b11
  } stage_e;

  typedef enum logic [1:0] {
    S_IDLE        = 2'b00,
    S_WAIT_LEAVE  = 2'b01,
    S_WAIT_RETURN = 2'b10
  } sched_state_e;

  // Ops the main understands; everything else is dropped at the FIFO head.
  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_INPUT, OP_ADVANCE, OP_DUR, OP_GTH, OP_BTH,
      OP_GW, OP_BW, OP_INDPTR, OP_IDX: is_legal_op = 1'b1;
      default:                          is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ttt_instr_fifo.sv
// Synchronous 16-bit packet FIFO; a push is refused whenever full, even if
// a pop happens in the same cycle.
module ttt_instr_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [15:0] din,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output logic [15:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s, do_pop_s;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == {CW{1'b0}});
  assign head      = mem_q[rd_ptr_q];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Pointer, occupancy and storage next-state.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ttt_instr_scheduler.sv
// Buffers host packets and issues them to the ttt main one per slot, holding
// off while an advance tick is in flight; optionally injects periodic ticks.
module ttt_instr_scheduler
  import ttt_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int TICK_BITS     = 8,
  parameter int LEAVE_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_pkt,
  input  logic [1:0]           stage,
  output logic [3:0]           instr_out,
  output logic [11:0]          data_out,
  input  logic                 tick_en,
  input  logic [TICK_BITS-1:0] tick_period,
  output logic                 busy,
  output logic [7:0]           drop_count,
  output logic                 stall_err,
  output logic                 tick_overrun
);

  localparam int LW = $clog2(LEAVE_TIMEOUT + 1);

  sched_state_e         state_q, state_d;
  logic [LW-1:0]        leave_cnt_q, leave_cnt_d;
  logic [TICK_BITS-1:0] tick_cnt_q, tick_cnt_d;
  logic                 tick_pending_q, tick_pending_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;
  logic                 stall_err_q, stall_err_d;
  logic                 overrun_q, overrun_d;
  logic [3:0]           instr_q, instr_d;
  logic [11:0]          data_q, data_d;

  logic        fifo_full_s, fifo_empty_s, fifo_pop_s;
  logic [15:0] fifo_head_s;
  logic [3:0]  head_op_s;
  logic        slot_s, head_legal_s, issue_tick_s, issue_fifo_s, drop_s;
  logic        issued_adv_s, tick_active_s, tick_wrap_s;

  ttt_instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .din   (in_pkt),
    .pop   (fifo_pop_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .head  (fifo_head_s)
  );

  // Reserved ops are discarded regardless of slot so junk never blocks the queue.
  assign head_op_s     = fifo_head_s[15:12];
  assign head_legal_s  = is_legal_op(head_op_s);
  assign slot_s        = (state_q == S_IDLE) && (stage == STAGE_WAIT);
  assign issue_tick_s  = slot_s && tick_pending_q;
  assign issue_fifo_s  = slot_s && !tick_pending_q && !fifo_empty_s && head_legal_s;
  assign drop_s        = !fifo_empty_s && !head_legal_s;
  assign fifo_pop_s    = issue_fifo_s || drop_s;
  assign issued_adv_s  = issue_tick_s || (issue_fifo_s && (head_op_s == OP_ADVANCE));
  assign tick_active_s = tick_en && (tick_period != {TICK_BITS{1'b0}});
  assign tick_wrap_s   = tick_active_s && (tick_cnt_q == tick_period - TICK_BITS'(1));

  // State register and all other flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      leave_cnt_q    <= {LW{1'b0}};
      tick_cnt_q     <= {TICK_BITS{1'b0}};
      tick_pending_q <= 1'b0;
      drop_cnt_q     <= 8'd0;
      stall_err_q    <= 1'b0;
      overrun_q      <= 1'b0;
      instr_q        <= OP_NOP;
      data_q         <= 12'd0;
    end else begin
      state_q        <= state_d;
      leave_cnt_q    <= leave_cnt_d;
      tick_cnt_q     <= tick_cnt_d;
      tick_pending_q <= tick_pending_d;
      drop_cnt_q     <= drop_cnt_d;
      stall_err_q    <= stall_err_d;
      overrun_q      <= overrun_d;
      instr_q        <= instr_d;
      data_q         <= data_d;
    end
  end

  // Next-state logic for the tick handshake with the main.
  always_comb begin
    state_d     = state_q;
    leave_cnt_d = leave_cnt_q;
    stall_err_d = stall_err_q;
    case (state_q)
      S_IDLE: begin
        if (issued_adv_s) begin
          state_d     = S_WAIT_LEAVE;
          leave_cnt_d = {LW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_LEAVE: begin
        if (stage != STAGE_WAIT) begin
          state_d = S_WAIT_RETURN;
        end else if (leave_cnt_q + LW'(1) == LW'(LEAVE_TIMEOUT)) begin
          leave_cnt_d = leave_cnt_q + LW'(1);
          state_d     = S_IDLE;
          stall_err_d = 1'b1;
        end else begin
          leave_cnt_d = leave_cnt_q + LW'(1);
        end
      end
      S_WAIT_RETURN: begin
        if (stage == STAGE_WAIT) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_RETURN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Issue outputs, drop counting and auto-tick generation.
  always_comb begin
    instr_d        = OP_NOP;
    data_d         = 12'd0;
    drop_cnt_d     = drop_cnt_q;
    tick_cnt_d     = tick_cnt_q;
    tick_pending_d = tick_pending_q;
    overrun_d      = overrun_q;

    if (issue_tick_s) begin
      instr_d = OP_ADVANCE;
      data_d  = 12'd0;
    end else if (issue_fifo_s) begin
      instr_d = head_op_s;
      data_d  = fifo_head_s[11:0];
    end else begin
      instr_d = OP_NOP;
    end

    if (drop_s && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end

    // A wrap with an unconsumed tick is an overrun; a tick consumed this cycle is not.
    if (!tick_active_s) begin
      tick_cnt_d     = {TICK_BITS{1'b0}};
      tick_pending_d = 1'b0;
    end else if (tick_wrap_s) begin
      tick_cnt_d     = {TICK_BITS{1'b0}};
      tick_pending_d = 1'b1;
      overrun_d      = overrun_q || (tick_pending_q && !issue_tick_s);
    end else begin
      tick_cnt_d     = tick_cnt_q + TICK_BITS'(1);
      tick_pending_d = tick_pending_q && !issue_tick_s;
    end
  end

  assign in_ready     = !fifo_full_s;
  assign busy         = (state_q != S_IDLE);
  assign instr_out    = instr_q;
  assign data_out     = data_q;
  assign drop_count   = drop_cnt_q;
  assign stall_err    = stall_err_q;
  assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_ttt_instr_scheduler.sv
// Scoreboard bench for ttt_instr_scheduler: stimulus queues expected issues,
// a negedge monitor pops and compares every non-NOP instruction.
module tb_ttt_instr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_pkt = 16'h0000;
  logic [1:0]  stage = 2'b00;
  logic [3:0]  instr_out;
  logic [11:0] data_out;
  logic        tick_en = 1'b0;
  logic [7:0]  tick_period = 8'd0;
  logic        busy;
  logic [7:0]  drop_count;
  logic        stall_err;
  logic        tick_overrun;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb[$];
  bit          tick_mode = 1'b0;
  int          tick_seen = 0;
  int          tick_base = 0;

  ttt_instr_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pkt       (in_pkt),
    .stage        (stage),
    .instr_out    (instr_out),
    .data_out     (data_out),
    .tick_en      (tick_en),
    .tick_period  (tick_period),
    .busy         (busy),
    .drop_count   (drop_count),
    .stall_err    (stall_err),
    .tick_overrun (tick_overrun)
  );

  always #5 clk = ~clk;

  // Monitor: every real op must match the head of the expected stream.
  always @(negedge clk) begin
    logic [15:0] exp_pkt;
    if (rst_n === 1'b1 && instr_out !== 4'd0) begin
      checks++;
      if (tick_mode) begin
        tick_seen++;
        if ({instr_out, data_out} !== 16'h2000) begin
          errors++;
          $display("FAIL tick_issue: got %h expected 2000", {instr_out, data_out});
        end
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue: got %h expected none", {instr_out, data_out});
      end else begin
        exp_pkt = sb.pop_front();
        if ({instr_out, data_out} !== exp_pkt) begin
          errors++;
          $display("FAIL issue_stream: got %h expected %h", {instr_out, data_out}, exp_pkt);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [15:0] p);
    in_valid = 1'b1;
    in_pkt   = p;
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Power-on reset
    step();
    step();
    chk("rst_instr", 32'(instr_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_stall", 32'(stall_err), 32'd0);
    chk("rst_overrun", 32'(tick_overrun), 32'd0);
    rst_n = 1'b1;
    step();

    // Reset in WAIT_RETURN with three queued packets
    sb.push_back(16'h2000);
    push_one(16'h2000);
    push_one(16'h9111);
    stage = 2'b01;
    push_one(16'h9222);
    push_one(16'h9333);
    chk("midtick_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_instr", 32'(instr_out), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_drop", 32'(drop_count), 32'd0);
    stage = 2'b00;
    repeat (6) step();
    chk("mid_rst_sb_empty", 32'(sb.size()), 32'd0);

    // Single legal op: one-cycle latency, one-cycle pulse
    sb.push_back(16'h9305);
    push_one(16'h9305);
    chk("lat_e0_instr", 32'(instr_out), 32'd0);
    step();
    chk("lat_e1_instr", 32'(instr_out), 32'h9);
    chk("lat_e1_data", 32'(data_out), 32'h305);
    step();
    chk("pulse_end_instr", 32'(instr_out), 32'd0);
    chk("pulse_end_data", 32'(data_out), 32'd0);

    // Advance followed by a held op
    sb.push_back(16'h2000);
    sb.push_back(16'hA055);
    push_one(16'h2000);
    push_one(16'hA055);
    chk("adv_instr", 32'(instr_out), 32'h2);
    chk("adv_busy0", 32'(busy), 32'd1);
    stage = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("adv_busy_hold", 32'(busy), 32'd1);
      chk("adv_hold_instr", 32'(instr_out), 32'd0);
    end
    stage = 2'b00;
    step();
    chk("ret_busy", 32'(busy), 32'd0);
    chk("ret_no_issue", 32'(instr_out), 32'd0);
    step();
    chk("held_instr", 32'(instr_out), 32'hA);
    chk("held_data", 32'(data_out), 32'h055);
    step();

    // Reserved op dropped, next op issued right after
    sb.push_back(16'h1F00);
    push_one(16'h3123);
    push_one(16'h1F00);
    chk("drop_count1", 32'(drop_count), 32'd1);
    chk("drop_no_issue", 32'(instr_out), 32'd0);
    step();
    chk("after_drop_instr", 32'(instr_out), 32'h1);
    chk("after_drop_data", 32'(data_out), 32'hF00);
    step();

    // Auto tick every 3 cycles with an instantly responding main
    tick_mode   = 1'b1;
    tick_seen   = 0;
    tick_period = 8'd3;
    tick_en     = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      stage = (instr_out == 4'h2) ? 2'b01 : 2'b00;
    end
    chk("tick_count", 32'(tick_seen), 32'd6);
    chk("tick_no_overrun", 32'(tick_overrun), 32'd0);
    stage = 2'b01;
    repeat (10) step();
    chk("tick_overrun", 32'(tick_overrun), 32'd1);
    tick_base   = tick_seen;
    tick_period = 8'd200;
    stage       = 2'b00;
    for (int i = 0; i < 12; i++) begin
      step();
      stage = (instr_out == 4'h2) ? 2'b01 : 2'b00;
    end
    chk("tick_after_release", 32'(tick_seen - tick_base), 32'd1);
    tick_en = 1'b0;
    stage   = 2'b00;
    step();
    step();
    tick_mode = 1'b0;

    // Stalled advance while the FIFO fills up
    sb.push_back(16'h2000);
    sb.push_back(16'h9001);
    sb.push_back(16'h9002);
    sb.push_back(16'h9003);
    sb.push_back(16'h9004);
    push_one(16'h2000);
    push_one(16'h9001);
    push_one(16'h9002);
    push_one(16'h9003);
    push_one(16'h9004);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_not_yet", 32'(stall_err), 32'd0);
    push_one(16'h9005);
    chk("timeout_busy", 32'(busy), 32'd0);
    chk("stall_err", 32'(stall_err), 32'd1);
    repeat (8) step();
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("drain_in_ready", 32'(in_ready), 32'd1);
    chk("stall_sticky", 32'(stall_err), 32'd1);
    chk("overrun_sticky", 32'(tick_overrun), 32'd1);
    chk("drop_final", 32'(drop_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
